// File: rtl/cc_mux_scan_ctrl.sv
// cc_mux_scan_ctrl
// Walks an analog/digital mux through a channel range [First..Last]. For each
// channel it drives the selection, waits for the mux output to settle,
// captures the bus, and offers the word through a valid/ready handshake.
// Invalid ranges are rejected with a one-cycle error pulse. Abort returns to
// idle immediately. All outputs come straight from registers.
module cc_mux_scan_ctrl #(
    parameter int DATAWIDTH_MUX_SELECTION = 6,
    parameter int DATAWIDTH_BUS           = 32,
    parameter int NUM_CHANNELS            = 38,
    parameter int SETTLE_CYCLES           = 2
) (
    input  logic                               CC_MUX_SCAN_CLOCK_50,
    input  logic                               CC_MUX_SCAN_RESET_InLow,
    input  logic                               CC_MUX_SCAN_Start_In,
    input  logic                               CC_MUX_SCAN_Abort_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_MUX_SCAN_FirstCh_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_MUX_SCAN_LastCh_In,
    input  logic [DATAWIDTH_BUS-1:0]           CC_MUX_SCAN_MuxData_In,
    input  logic                               CC_MUX_SCAN_Ready_In,
    output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_MUX_SCAN_Selection_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_MUX_SCAN_Data_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_MUX_SCAN_Channel_Out,
    output logic                               CC_MUX_SCAN_Valid_Out,
    output logic                               CC_MUX_SCAN_Busy_Out,
    output logic                               CC_MUX_SCAN_Done_Out,
    output logic                               CC_MUX_SCAN_Error_Out
);

    localparam int SEL_W = DATAWIDTH_MUX_SELECTION;
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    // One extra bit so NUM_CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   C_NUM_CH  = (SEL_W + 1)'(NUM_CHANNELS);
    localparam logic [CNT_W-1:0] C_SETTLE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [SEL_W-1:0] C_SEL_ONE = SEL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        r_first;
    logic [SEL_W-1:0]        r_last;
    logic [SEL_W-1:0]        r_sel;
    logic [SEL_W-1:0]        r_chan;
    logic [DATAWIDTH_BUS-1:0] r_data;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    w_range_ok;

    // Range check for a start request: ordered and inside the channel count.
    always_comb begin
        w_range_ok = (CC_MUX_SCAN_FirstCh_In <= CC_MUX_SCAN_LastCh_In) &&
                     ({1'b0, CC_MUX_SCAN_LastCh_In} < C_NUM_CH);
    end

    // Scan sequencer: state, channel pointer, capture registers and status flags.
    always_ff @(posedge CC_MUX_SCAN_CLOCK_50) begin
        // NOTE: every register here is updated with <= so all branches see the
        // pre-edge values; a blocking write would leak into later reads.
        if (!CC_MUX_SCAN_RESET_InLow) begin
            r_state <= S_IDLE;
            r_first <= '0;
            r_last  <= '0;
            r_sel   <= '0;
            r_chan  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            // Pulses default low and are raised only on the cycle they apply.
            r_done  <= 1'b0;
            r_error <= 1'b0;

            if ((r_state != S_IDLE) && CC_MUX_SCAN_Abort_In) begin
                // Abort outranks the handshake and the DONE exit.
                r_state <= S_IDLE;
                r_sel   <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (CC_MUX_SCAN_Abort_In) begin
                            r_state <= S_IDLE;
                        end else if (CC_MUX_SCAN_Start_In) begin
                            if (w_range_ok) begin
                                r_first <= CC_MUX_SCAN_FirstCh_In;
                                r_last  <= CC_MUX_SCAN_LastCh_In;
                                r_sel   <= CC_MUX_SCAN_FirstCh_In;
                                r_cnt   <= C_SETTLE;
                                r_busy  <= 1'b1;
                                r_state <= S_SETTLE;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt <= C_CNT_ONE) begin
                            r_cnt   <= '0;
                            r_state <= S_CAPTURE;
                        end else begin
                            r_cnt <= r_cnt - C_CNT_ONE;
                        end
                    end
                    S_CAPTURE: begin
                        r_data  <= CC_MUX_SCAN_MuxData_In;
                        r_chan  <= r_sel;
                        r_valid <= 1'b1;
                        r_state <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (CC_MUX_SCAN_Ready_In) begin
                            r_valid <= 1'b0;
                            if (r_sel == r_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_sel   <= r_sel + C_SEL_ONE;
                                r_cnt   <= C_SETTLE;
                                r_state <= S_SETTLE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sel   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CC_MUX_SCAN_Selection_Out = r_sel;
    assign CC_MUX_SCAN_Data_Out      = r_data;
    assign CC_MUX_SCAN_Channel_Out   = r_chan;
    assign CC_MUX_SCAN_Valid_Out     = r_valid;
    assign CC_MUX_SCAN_Busy_Out      = r_busy;
    assign CC_MUX_SCAN_Done_Out      = r_done;
    assign CC_MUX_SCAN_Error_Out     = r_error;

endmodule

// File: tb/tb_cc_mux_scan_ctrl.sv
// tb_cc_mux_scan_ctrl
// Self-checking bench. A transaction-level model predicts, per cycle, which
// channel should be selected, when each word becomes valid, and when Done
// fires, using only the latency rules of the scanner. The mux is modelled as
// a lookup table indexed by the DUT's selection output.
module tb_cc_mux_scan_ctrl;

    localparam int SEL_W  = 6;
    localparam int BUS_W  = 32;
    localparam int NUM_CH = 38;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [SEL_W-1:0]  first_ch;
    logic [SEL_W-1:0]  last_ch;
    logic [BUS_W-1:0]  mux_data;
    logic              rdy_in;
    logic [SEL_W-1:0]  sel_o;
    logic [BUS_W-1:0]  data_o;
    logic [SEL_W-1:0]  chan_o;
    logic              valid_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    logic [BUS_W-1:0]  mux_mem [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mux_data = mux_mem[sel_o];

    cc_mux_scan_ctrl #(
        .DATAWIDTH_MUX_SELECTION(SEL_W),
        .DATAWIDTH_BUS          (BUS_W),
        .NUM_CHANNELS           (NUM_CH),
        .SETTLE_CYCLES          (SETTLE)
    ) dut (
        .CC_MUX_SCAN_CLOCK_50     (clk),
        .CC_MUX_SCAN_RESET_InLow  (rst_n),
        .CC_MUX_SCAN_Start_In     (start),
        .CC_MUX_SCAN_Abort_In     (abort),
        .CC_MUX_SCAN_FirstCh_In   (first_ch),
        .CC_MUX_SCAN_LastCh_In    (last_ch),
        .CC_MUX_SCAN_MuxData_In   (mux_data),
        .CC_MUX_SCAN_Ready_In     (rdy_in),
        .CC_MUX_SCAN_Selection_Out(sel_o),
        .CC_MUX_SCAN_Data_Out     (data_o),
        .CC_MUX_SCAN_Channel_Out  (chan_o),
        .CC_MUX_SCAN_Valid_Out    (valid_o),
        .CC_MUX_SCAN_Busy_Out     (busy_o),
        .CC_MUX_SCAN_Done_Out     (done_o),
        .CC_MUX_SCAN_Error_Out    (error_o)
    );

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mux_mem[i] = $urandom;
    endtask

    // Runs one scan of [first..last] starting at the next edge and checks every
    // cycle against the model. Ready is held low for ready_hold cycles, then
    // random with ready_pct percent. With noise set, Start and range inputs
    // are toggled randomly while the scan is running.
    task automatic run_scan(input int first, input int last, input int ready_hold,
                            input int ready_pct, input bit noise);
        int t, exp_ch, next_valid, done_edge, words, guard;
        bit exp_valid;
        first_ch = SEL_W'(first);
        last_ch  = SEL_W'(last);
        start    = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        t          = 0;
        exp_ch     = first;
        next_valid = SETTLE + 1;
        done_edge  = -1;
        words      = 0;
        guard      = 3000;
        while ((done_edge < 0 || t <= done_edge + 2) && t < guard) begin
            if (error_o !== 1'b0) begin
                bad++; $display("FAIL scan_error t=%0d got=%b want=0", t, error_o);
            end
            total++;
            if (done_edge < 0) begin
                exp_valid = (t >= next_valid);
                if (valid_o !== exp_valid) begin
                    bad++; $display("FAIL scan_valid t=%0d ch=%0d got=%b want=%b", t, exp_ch, valid_o, exp_valid);
                end
                total++;
                if ({busy_o, done_o} !== 2'b10) begin
                    bad++; $display("FAIL scan_busy_done t=%0d got=%b%b want=10", t, busy_o, done_o);
                end
                total++;
                if (sel_o !== SEL_W'(exp_ch)) begin
                    bad++; $display("FAIL scan_sel t=%0d got=%0d want=%0d", t, sel_o, exp_ch);
                end
                total++;
                if (exp_valid && valid_o) begin
                    if (data_o !== mux_mem[exp_ch] || chan_o !== SEL_W'(exp_ch)) begin
                        bad++;
                        $display("FAIL scan_word t=%0d got=%0d:%h want=%0d:%h",
                                 t, chan_o, data_o, exp_ch, mux_mem[exp_ch]);
                    end
                    total++;
                end
                rdy_in = (t >= ready_hold) && ($urandom_range(99) < ready_pct);
                if (exp_valid && rdy_in) begin
                    words++;
                    if (exp_ch == last) done_edge = t + 1;
                    else begin
                        exp_ch++;
                        next_valid = t + 1 + SETTLE + 1;
                    end
                end
                if (noise) begin
                    start    = 1'($urandom_range(1));
                    first_ch = SEL_W'($urandom_range(NUM_CH - 1));
                    last_ch  = SEL_W'($urandom_range(NUM_CH - 1));
                end
            end else if (t == done_edge) begin
                start  = 1'b0;
                rdy_in = 1'($urandom_range(1));
                if ({busy_o, done_o, valid_o} !== 3'b110) begin
                    bad++; $display("FAIL done_cycle t=%0d got=%b%b%b want=110", t, busy_o, done_o, valid_o);
                end
                total++;
            end else begin
                rdy_in = 1'($urandom_range(1));
                if ({busy_o, done_o, valid_o} !== 3'b000 || sel_o !== '0) begin
                    bad++; $display("FAIL after_done t=%0d got=%b%b%b sel=%0d want=000 sel=0",
                                    t, busy_o, done_o, valid_o, sel_o);
                end
                total++;
            end
            @(negedge clk);
            t++;
        end
        if (t >= guard || words != last - first + 1) begin
            bad++; $display("FAIL scan_words got=%0d want=%0d t=%0d", words, last - first + 1, t);
        end
        total++;
        start  = 1'b0;
        rdy_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom_range(1));
            abort    = 1'($urandom_range(1));
            rdy_in   = 1'($urandom_range(1));
            first_ch = SEL_W'($urandom_range(10));
            last_ch  = SEL_W'($urandom_range(10, 20));
            @(negedge clk);
            if ({sel_o, data_o, chan_o, valid_o, busy_o, done_o, error_o} !== '0) begin
                bad++; $display("FAIL reset_outputs cyc=%0d got=%h want=0", i,
                                {sel_o, data_o, chan_o, valid_o, busy_o, done_o, error_o});
            end
            total++;
        end
        start = 1'b0; abort = 1'b0; rdy_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scan();
        for (int i = 0; i < 64; i++) mux_mem[i] = 32'(i) * 32'h1111_1111;
        run_scan(0, NUM_CH - 1, 0, 100, 1'b0);
    endtask

    task automatic test_latency_backpressure();
        fill_random();
        // Start at edge k: Valid from k+3, Ready first high in the cycle ending
        // at edge k+10, so Valid drops and Done rises right after that edge.
        run_scan(5, 5, 9, 100, 1'b0);
    endtask

    task automatic test_invalid_range();
        int f, l;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin f = 7; l = 3; end
            else if (i == 1) begin f = 0; l = NUM_CH; end
            else if (i[0]) begin f = $urandom_range(1, NUM_CH - 1); l = $urandom_range(f - 1); end
            else begin l = $urandom_range(NUM_CH, 63); f = $urandom_range(l); end
            first_ch = SEL_W'(f);
            last_ch  = SEL_W'(l);
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if ({error_o, busy_o, valid_o} !== 3'b100 || sel_o !== '0) begin
                bad++; $display("FAIL invalid_pulse f=%0d l=%0d got=%b%b%b sel=%0d want=100 sel=0",
                                f, l, error_o, busy_o, valid_o, sel_o);
            end
            total++;
            @(negedge clk);
            if ({error_o, busy_o, valid_o} !== 3'b000 || sel_o !== '0) begin
                bad++; $display("FAIL invalid_after f=%0d l=%0d got=%b%b%b sel=%0d want=000 sel=0",
                                f, l, error_o, busy_o, valid_o, sel_o);
            end
            total++;
        end
    endtask

    task automatic test_abort();
        int  n;
        bit  any_done;
        fill_random();
        first_ch = 0; last_ch = 9; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rdy_in = 1'b1;
        n      = 0;
        while (!(valid_o === 1'b1 && chan_o === SEL_W'(2)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100 || data_o !== mux_mem[2]) begin
            bad++; $display("FAIL abort_reach n=%0d got=%h want=%h", n, data_o, mux_mem[2]);
        end
        total++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if ({valid_o, busy_o, done_o} !== 3'b000 || sel_o !== '0) begin
            bad++; $display("FAIL abort_idle got=%b%b%b sel=%0d want=000 sel=0", valid_o, busy_o, done_o, sel_o);
        end
        total++;
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_done |= done_o | busy_o | valid_o;
        end
        if (any_done !== 1'b0) begin
            bad++; $display("FAIL abort_quiet got=%b want=0", any_done);
        end
        total++;
        // Abort together with Start in idle: nothing starts.
        first_ch = 1; last_ch = 4; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        if ({busy_o, error_o} !== 2'b00) begin
            bad++; $display("FAIL abort_start_idle got=%b%b want=00", busy_o, error_o);
        end
        total++;
        run_scan(3, 6, 0, 60, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        int n;
        fill_random();
        first_ch = 0; last_ch = 9; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rdy_in = 1'b1;
        n      = 0;
        while (!(sel_o === SEL_W'(4) && valid_o === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100 || busy_o !== 1'b1) begin
            bad++; $display("FAIL rst_reach n=%0d busy=%b want=1", n, busy_o);
        end
        total++;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom_range(1));
            first_ch = SEL_W'($urandom_range(5));
            last_ch  = SEL_W'($urandom_range(5, 30));
            @(negedge clk);
            if ({sel_o, data_o, chan_o, valid_o, busy_o, done_o, error_o} !== '0) begin
                bad++; $display("FAIL rst_mid cyc=%0d got=%h want=0", i,
                                {sel_o, data_o, chan_o, valid_o, busy_o, done_o, error_o});
            end
            total++;
        end
        start = 1'b0; rdy_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if ({busy_o, valid_o, done_o} !== 3'b000) begin
            bad++; $display("FAIL rst_release got=%b%b%b want=000", busy_o, valid_o, done_o);
        end
        total++;
        run_scan(2, 5, 0, 80, 1'b0);
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_scan(0, 3, 0, 70, 1'b1);
    endtask

    task automatic test_back_to_back();
        int f, l;
        for (int i = 0; i < 6; i++) begin
            fill_random();
            f = $urandom_range(NUM_CH - 1);
            l = $urandom_range(f, (f + 6 < NUM_CH) ? f + 6 : NUM_CH - 1);
            run_scan(f, l, $urandom_range(4), $urandom_range(30, 100), 1'($urandom_range(1)));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rdy_in = 1'b0;
        first_ch = '0; last_ch = '0;
        for (int i = 0; i < 64; i++) mux_mem[i] = '0;
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_latency_backpressure();
        test_invalid_range();
        test_abort();
        test_reset_mid_scan();
        test_start_while_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_mux_scan_ctrl.md
CC_MUX_SCAN_CTRL -- requirements
Module: CC_MUX_SCAN_CTRL

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATAWIDTH_MUX_SELECTION, 6, select width.
- DATAWIDTH_BUS, 32, data width.
- NUM_CHANNELS, 38, valid channels 0..37.
- SETTLE_CYCLES, 2, mux settle cycles, at least 1.
REQ-002 Clock and reset SHALL be: one clock, CC_MUX_SCAN_CLOCK_50, all logic on its rising edge; reset CC_MUX_SCAN_RESET_InLow is synchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- CC_MUX_SCAN_CLOCK_50, in, 1, clock.
- CC_MUX_SCAN_RESET_InLow, in, 1, sync reset, active low.
- CC_MUX_SCAN_Start_In, in, 1, start-scan request.
- CC_MUX_SCAN_Abort_In, in, 1, abort current scan.
- CC_MUX_SCAN_FirstCh_In, in, SEL, first channel of range.
- CC_MUX_SCAN_LastCh_In, in, SEL, last channel of range.
- CC_MUX_SCAN_MuxData_In, in, BUS, output bus of the selected mux.
- CC_MUX_SCAN_Ready_In, in, 1, consumer accepts word.
- CC_MUX_SCAN_Selection_Out, out, SEL, drives mux selection input.
- CC_MUX_SCAN_Data_Out, out, BUS, captured word.
- CC_MUX_SCAN_Channel_Out, out, SEL, channel of Data_Out.
- CC_MUX_SCAN_Valid_Out, out, 1, word available.
- CC_MUX_SCAN_Busy_Out, out, 1, scan in progress.
- CC_MUX_SCAN_Done_Out, out, 1, one-cycle scan-complete pulse.
- CC_MUX_SCAN_Error_Out, out, 1, one-cycle invalid-range pulse.

Function
REQ-004 FSM states SHALL be IDLE, SETTLE, CAPTURE, WAIT_ACK, DONE; all outputs registered.
REQ-005 In IDLE, Start=1 with First<=Last<NUM_CHANNELS SHALL latch First/Last, set Selection_Out=First, load settle counter=SETTLE_CYCLES and enter SETTLE.
REQ-006 In IDLE, Start=1 with an invalid range SHALL pulse Error_Out for exactly one cycle and remain in IDLE; Selection_Out stays 0.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CAPTURE; Selection_Out is held constant throughout.
REQ-008 CAPTURE SHALL last one cycle and register MuxData_In into Data_Out and Selection_Out into Channel_Out, then enter WAIT_ACK.
REQ-009 In WAIT_ACK:
- Valid_Out=1.
- Data_Out and Channel_Out are stable.
- State is held until Ready_In=1.
REQ-010 The handshake SHALL complete on the cycle where Valid_Out=1 and Ready_In=1. Valid_Out deasserts the next cycle. Ready_In is ignored while Valid_Out=0.
REQ-011 On handshake, if Selection_Out==Last the FSM SHALL go to DONE; otherwise Selection_Out increments by 1 and the FSM enters SETTLE. No wrap-around occurs; Selection_Out never exceeds Last.
REQ-012 DONE SHALL assert Done_Out for one cycle, reset Selection_Out to 0, and return to IDLE.
REQ-013 Busy_Out SHALL be 1 in SETTLE, CAPTURE, WAIT_ACK and DONE, and 0 in IDLE.
REQ-014 Start_In SHALL be ignored while Busy_Out=1.
REQ-015 Abort_In=1 in any non-IDLE state SHALL cause the next state to be IDLE:
- Valid_Out=0 and Selection_Out=0.
- No Done_Out pulse.
- Abort has priority over Ready_In and over the DONE transition.
REQ-016 Abort_In and Start_In both high in IDLE: Abort SHALL win and no scan starts.
REQ-017 Latency: Start sampled at edge k SHALL give first Valid_Out=1 at cycle k+SETTLE_CYCLES+2. Each following word appears SETTLE_CYCLES+2 cycles after the previous handshake.
REQ-018 First==Last SHALL produce exactly one word, then Done.

Reset
REQ-019 RESET_InLow=0 at a clock edge SHALL force IDLE, including mid-scan, and clear:
- Selection_Out=0, Data_Out=0, Channel_Out=0.
- Valid_Out=0, Busy_Out=0, Done_Out=0, Error_Out=0.
- Latched First/Last=0 and settle counter=0.
REQ-020 Reset SHALL take priority over Start, Abort and Ready.

Verification
REQ-021 Full scan: SETTLE_CYCLES=2, First=0, Last=37, Ready tied 1, MuxData=channel*0x11111111 -> 38 words on channels 0..37 with the matching data; Done pulses once; Busy falls with DONE.
REQ-022 Latency and backpressure: Start at edge 10, First=Last=5, Ready=0 until cycle 20 -> Valid=1 from cycle 14; Data/Channel=5 held through cycle 20; Valid=0 at 21; Done=1 at 21.
REQ-023 Invalid range: First=7, Last=3, and separately First=0, Last=38 -> one-cycle Error each; Busy stays 0; Selection stays 0.
REQ-024 Abort: Abort in WAIT_ACK on channel 2 of range 0..9, with Ready=1 in the same cycle -> IDLE next cycle; Valid=0; no Done; a new Start is then accepted normally.
REQ-025 Reset mid-scan: RESET_InLow=0 during SETTLE of channel 4 -> all outputs 0 next cycle; Start pulses during reset are ignored.
REQ-026 Start while Busy: Start pulses during an active scan 0..3 -> no restart; exactly 4 words and 1 Done.
